// File: rtl/regfile_wb_queue.sv
// Register-file write-back queue: merges load and ALU results in program order and retires one per cycle.
// Optional macro FORWARD_EN enables the q_addr/q_hit/q_data youngest-match forwarding search.
module regfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_W-1:0]     alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  output logic [ADDR_W-1:0]     wAddr,
  output logic [DATA_W-1:0]     wDin,
  output logic                  wEna,
  output logic [2**ADDR_W-1:0]  pending,
  input  logic [ADDR_W-1:0]     q_addr,
  output logic                  q_hit,
  output logic [DATA_W-1:0]     q_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdin;
  logic              r_wena;

  logic [CNT_W-1:0]  w_free;
  logic              w_push_mem;
  logic              w_push_alu;
  logic              w_pop;
  logic [1:0]        w_push_n;
  logic [PTR_W-1:0]  w_alu_idx;
  logic [PTR_W-1:0]  w_age [DEPTH];
  logic [DEPTH-1:0]  w_entry_valid;
  logic [NREG-1:0]   w_pending;

  // Readiness looks only at the registered count; a pop in the same cycle earns no credit.
  assign w_free     = DEPTH_C - r_count;
  assign mem_ready  = !rst && (w_free != '0);
  assign alu_ready  = !rst && (w_free >= CNT_W'(2));

  // Writes to r0 complete the handshake but never occupy a slot.
  assign w_push_mem = mem_valid && mem_ready && (mem_addr != '0);
  assign w_push_alu = alu_valid && alu_ready && (alu_addr != '0);
  assign w_pop      = (r_count != '0);
  assign w_push_n   = {1'b0, w_push_mem} + {1'b0, w_push_alu};
  assign w_alu_idx  = r_wr_ptr + PTR_W'(w_push_mem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_waddr  <= '0;
      r_wdin   <= '0;
      r_wena   <= 1'b0;
    end else begin
      if (w_push_mem) begin
        r_fifo_addr[r_wr_ptr] <= mem_addr;
        r_fifo_data[r_wr_ptr] <= mem_data;
      end
      if (w_push_alu) begin
        r_fifo_addr[w_alu_idx] <= alu_addr;
        r_fifo_data[w_alu_idx] <= alu_data;
      end
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      r_count  <= r_count + CNT_W'(w_push_n) - CNT_W'(w_pop);
      r_wena   <= w_pop;
      if (w_pop) begin
        r_waddr  <= r_fifo_addr[r_rd_ptr];
        r_wdin   <= r_fifo_data[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  assign wAddr = r_waddr;
  assign wDin  = r_wdin;
  assign wEna  = r_wena;

  // An entry is live when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign w_age[gi]         = PTR_W'(gi) - r_rd_ptr;
      assign w_entry_valid[gi] = ({1'b0, w_age[gi]} < r_count);
    end
  endgenerate

  always_comb begin
    w_pending = '0;
    if (r_wena) w_pending[r_waddr] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i]) w_pending[r_fifo_addr[i]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end
  assign pending = w_pending;

`ifdef FORWARD_EN
  logic              w_q_hit;
  logic [DATA_W-1:0] w_q_data;
  logic [PTR_W-1:0]  w_idx;

  // Walk oldest to youngest so the last match is the youngest write.
  always_comb begin
    w_q_hit  = 1'b0;
    w_q_data = '0;
    w_idx    = '0;
    if (r_wena && r_waddr == q_addr) begin
      w_q_hit  = 1'b1;
      w_q_data = r_wdin;
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && r_fifo_addr[w_idx] == q_addr) begin
        w_q_hit  = 1'b1;
        w_q_data = r_fifo_data[w_idx];
      end
    end
    if (q_addr == '0) begin
      w_q_hit  = 1'b0;
      w_q_data = '0;
    end
  end
  assign q_hit  = w_q_hit;
  assign q_data = w_q_data;
`else
  logic w_unused_q_addr;
  assign w_unused_q_addr = ^q_addr;
  assign q_hit  = 1'b0;
  assign q_data = '0;
`endif

endmodule
